// File: rtl/mandel_run_pkg.sv
// Shared state encoding, record layout and default timing for the Mandelbrot run monitor.
package mandel_run_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StDelay = 2'd1;
  localparam state_t StRun   = 2'd2;
  localparam state_t StDrain = 2'd3;

  localparam int unsigned DefStartDelay = 20;
  localparam int unsigned DefTimeout    = 2 ** 20;

  // Record layout for the default configuration (up to 16 channels, 32-bit ret and counter).
  localparam int unsigned RecChW  = 4;
  localparam int unsigned RecRetW = 32;
  localparam int unsigned RecCntW = 32;

  typedef struct packed {
    logic [RecChW-1:0]  ch;
    logic [RecRetW-1:0] ret;
    logic [RecCntW-1:0] cycles;
    logic               timeout;
  } rec_t;

endpackage

// File: rtl/mandel_run_chan.sv
// One DUT channel: ready rising-edge detect, done flag and ret/cycles/timeout slot.
module mandel_run_chan #(
  parameter int unsigned RET_W = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             run,
  input  logic             tmo,
  input  logic             ready,
  input  logic [RET_W-1:0] ret,
  input  logic [CNT_W-1:0] cnt,
  output logic             done,
  output logic             pend,
  output logic [RET_W-1:0] slot_ret,
  output logic [CNT_W-1:0] slot_cycles,
  output logic             slot_timeout
);

  logic             ready_q;
  logic             done_q, done_d;
  logic             pend_q, pend_d;
  logic             to_q, to_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             rise;

  assign rise = ready & ~ready_q;

  always_comb begin
    done_d = done_q;
    pend_d = pend_q;
    to_d   = to_q;
    ret_d  = ret_q;
    cyc_d  = cyc_q;
    if (clr) begin
      done_d = 1'b0;
      pend_d = 1'b0;
      to_d   = 1'b0;
      ret_d  = '0;
      cyc_d  = '0;
    end else if (run) begin
      // ret is taken one cycle after the ready edge so the DUT output can settle
      if (pend_q) begin
        ret_d  = ret;
        pend_d = 1'b0;
      end
      if (!done_q) begin
        if (tmo) begin
          done_d = 1'b1;
          to_d   = 1'b1;
          ret_d  = '0;
          cyc_d  = cnt;
        end else if (rise) begin
          done_d = 1'b1;
          pend_d = 1'b1;
          cyc_d  = cnt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      to_q    <= 1'b0;
      ret_q   <= '0;
      cyc_q   <= '0;
    end else begin
      ready_q <= ready;
      done_q  <= done_d;
      pend_q  <= pend_d;
      to_q    <= to_d;
      ret_q   <= ret_d;
      cyc_q   <= cyc_d;
    end
  end

  assign done         = done_q;
  assign pend         = pend_q;
  assign slot_ret     = ret_q;
  assign slot_cycles  = cyc_q;
  assign slot_timeout = to_q;

endmodule

// File: rtl/mandel_run_monitor.sv
// Multi-channel run harness: delayed start, per-channel cycle measurement, result streaming.
module mandel_run_monitor
  import mandel_run_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned RET_W       = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned START_DELAY = DefStartDelay,
  parameter int unsigned TIMEOUT     = DefTimeout,
  localparam int unsigned ChW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic                  busy,
  output logic [N_CH-1:0]       dut_start,
  input  logic [N_CH-1:0]       dut_ready,
  input  logic [N_CH*RET_W-1:0] dut_ret,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ChW-1:0]        res_ch,
  output logic [RET_W-1:0]      res_ret,
  output logic [CNT_W-1:0]      res_cycles,
  output logic                  res_timeout
);

  state_t           state_q, state_d;
  logic [31:0]      dly_q, dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ChW-1:0]   idx_q, idx_d, sel;
  logic             vld_q, vld_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             to_q, to_d;

  logic [N_CH-1:0]  done, pend, slot_to;
  logic [RET_W-1:0] slot_ret [N_CH];
  logic [CNT_W-1:0] slot_cyc [N_CH];
  logic [RET_W-1:0] mux_ret;
  logic [CNT_W-1:0] mux_cyc;
  logic             mux_to;
  logic             run, tmo, clr;

  assign run = (state_q == StRun);
  assign clr = (state_q == StIdle);
  assign tmo = run && ({32'd0, cnt_q} == (CNT_W + 32)'(TIMEOUT));

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    mandel_run_chan #(
      .RET_W(RET_W),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .clr         (clr),
      .run         (run),
      .tmo         (tmo),
      .ready       (dut_ready[i]),
      .ret         (dut_ret[i*RET_W +: RET_W]),
      .cnt         (cnt_q),
      .done        (done[i]),
      .pend        (pend[i]),
      .slot_ret    (slot_ret[i]),
      .slot_cycles (slot_cyc[i]),
      .slot_timeout(slot_to[i])
    );
  end

  // RUN loads record 0; DRAIN loads the record after the one just accepted
  assign sel = run ? '0 : idx_q + ChW'(1);

  always_comb begin
    mux_ret = '0;
    mux_cyc = '0;
    mux_to  = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ChW'(i) == sel) begin
        mux_ret = slot_ret[i];
        mux_cyc = slot_cyc[i];
        mux_to  = slot_to[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    ch_d    = ch_q;
    ret_d   = ret_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (go) begin
          dly_d   = '0;
          state_d = (START_DELAY == 0) ? StRun : StDelay;
        end
      end
      StDelay: begin
        if (dly_q == START_DELAY - 1) state_d = StRun;
        else dly_d = dly_q + 32'd1;
      end
      StRun: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if ((&done) && !(|pend)) begin
          state_d = StDrain;
          idx_d   = '0;
          vld_d   = 1'b1;
          ch_d    = sel;
          ret_d   = mux_ret;
          cyc_d   = mux_cyc;
          to_d    = mux_to;
        end
      end
      StDrain: begin
        if (vld_q && res_ready) begin
          if (idx_q == ChW'(N_CH - 1)) begin
            vld_d   = 1'b0;
            state_d = StIdle;
          end else begin
            idx_d = sel;
            ch_d  = sel;
            ret_d = mux_ret;
            cyc_d = mux_cyc;
            to_d  = mux_to;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      dly_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      ch_q    <= '0;
      ret_q   <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      ch_q    <= ch_d;
      ret_q   <= ret_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign dut_start   = {N_CH{run}};
  assign res_valid   = vld_q;
  assign res_ch      = ch_q;
  assign res_ret     = ret_q;
  assign res_cycles  = cyc_q;
  assign res_timeout = to_q;

endmodule

// File: tb/tb_mandel_run_monitor.sv
// Bench for mandel_run_monitor: directed vector table plus random batches against a waveform model.
module tb_mandel_run_monitor;
  import mandel_run_pkg::*;

  localparam int N  = 4;
  localparam int SD = 20;
  localparam int TO = 100;
  localparam int NV = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            go = 1'b0;
  logic            res_ready = 1'b0;
  logic [N-1:0]    dut_ready = '0;
  logic [N*32-1:0] dut_ret = '0;
  logic            busy, res_valid, res_timeout;
  logic [N-1:0]    dut_start;
  logic [1:0]      res_ch;
  logic [31:0]     res_ret, res_cycles;

  mandel_run_monitor #(
    .N_CH       (N),
    .RET_W      (32),
    .CNT_W      (32),
    .START_DELAY(SD),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .busy       (busy),
    .dut_start  (dut_start),
    .dut_ready  (dut_ready),
    .dut_ret    (dut_ret),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_ch     (res_ch),
    .res_ret    (res_ret),
    .res_cycles (res_cycles),
    .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:N-1]        pre;   // ready level before RUN
    logic [0:N-1][7:0]   fall;  // 8'hFF = no fall
    logic [0:N-1][7:0]   rise;  // 8'hFF = never rises
    logic [0:N-1][31:0]  ret;
    logic [1:0]          mode;  // res_ready: 0 always, 1 pattern 0,0,1,0,1, 2 random
    logic                noise; // random go pulses while busy
    logic [0:N-1][7:0]   ecyc;
    logic [0:N-1]        eto;
  } vec_t;

  vec_t        tbl [NV];
  int          total = 0;
  int          bad = 0;
  int          c_pre [N];
  int          c_fall [N];
  int          c_rise [N];
  int          det [N];
  int          e_cyc [N];
  bit          e_to [N];
  logic [31:0] c_ret [N];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ready waveform in run-relative cycles; a short dip after the rise exercises ignored re-toggles.
  function automatic bit level(input int i, input int t);
    bit lv;
    if (t < 0) return c_pre[i] != 0;
    lv = (c_pre[i] != 0) && (c_fall[i] < 0 || t < c_fall[i]);
    if (c_rise[i] >= 0 && t >= c_rise[i] && !(t >= c_rise[i] + 3 && t < c_rise[i] + 6)) lv = 1'b1;
    return lv;
  endfunction

  function automatic int first_rise(input int i);
    for (int t = 0; t < TO; t++) if (level(i, t) && !level(i, t - 1)) return t;
    return -1;
  endfunction

  task automatic drive_ch(input int t);
    for (int i = 0; i < N; i++) begin
      dut_ready[i] = level(i, t);
      dut_ret[i*32 +: 32] = (det[i] >= 0 && t > det[i]) ? c_ret[i] : ~c_ret[i];
    end
  endtask

  task automatic load_row(input vec_t v);
    for (int i = 0; i < N; i++) begin
      c_pre[i]  = int'(v.pre[i]);
      c_fall[i] = (v.fall[i] == 8'hFF) ? -1 : int'(v.fall[i]);
      c_rise[i] = (v.rise[i] == 8'hFF) ? -1 : int'(v.rise[i]);
      c_ret[i]  = v.ret[i];
      e_to[i]   = v.eto[i];
      e_cyc[i]  = int'(v.ecyc[i]);
      det[i]    = v.eto[i] ? -1 : e_cyc[i];
    end
  endtask

  task automatic rand_row();
    for (int i = 0; i < N; i++) begin
      c_pre[i] = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if (c_pre[i] != 0) begin
        c_fall[i] = int'($urandom_range(0, 10));
        c_rise[i] = ($urandom_range(0, 5) == 0) ? -1 : c_fall[i] + 1 + int'($urandom_range(0, 60));
      end else begin
        c_fall[i] = -1;
        c_rise[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 90));
      end
      c_ret[i] = $urandom;
      det[i]   = first_rise(i);
      e_to[i]  = (det[i] < 0);
      e_cyc[i] = (det[i] < 0) ? TO : det[i];
    end
  endtask

  task automatic run_batch(input int mode, input bit noise);
    int   t, drop, last, n, acc;
    bit   stalled;
    rec_t exp, act, prev;
    last = 0;
    for (int i = 0; i < N; i++) if (e_cyc[i] > last) last = e_cyc[i];
    step();
    go = 1'b1;
    res_ready = 1'b0;
    drive_ch(-1);
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_start", 128'(dut_start), 128'(0));
    for (int k = 0; k < SD; k++) begin
      step();
      go = noise ? 1'($urandom) : 1'b0;
      drive_ch(-1);
      chk("delay_busy", 128'(busy), 128'(1));
      chk("delay_start", 128'(dut_start), 128'(0));
    end
    step();
    go = noise ? 1'($urandom) : 1'b0;
    drive_ch(0);
    chk("start_rise", 128'(dut_start), 128'(4'hF));
    drop = -1;
    t = 1;
    while (drop < 0 && t <= TO + 8) begin
      step();
      go = noise ? 1'($urandom) : 1'b0;
      drive_ch(t);
      if (dut_start == '0) drop = t;
      else begin
        chk("run_start", 128'(dut_start), 128'(4'hF));
        chk("run_valid", 128'(res_valid), 128'(0));
        t++;
      end
    end
    chk("run_exit_window", 128'(drop >= last + 2 && drop <= last + 3), 128'(1));
    n = 0;
    acc = 0;
    stalled = 1'b0;
    prev = '0;
    while (acc < N && n < 64) begin
      if (n > 0) begin
        step();
        go = noise ? 1'($urandom) : 1'b0;
        t++;
        drive_ch(t);
      end
      case (mode)
        0:       res_ready = 1'b1;
        1:       res_ready = (n % 5 == 2) || (n % 5 == 4);
        default: res_ready = 1'($urandom);
      endcase
      act.ch = 4'(res_ch);
      act.ret = res_ret;
      act.cycles = res_cycles;
      act.timeout = res_timeout;
      chk("drain_valid", 128'(res_valid), 128'(1));
      if (stalled) chk("drain_hold", 128'(act), 128'(prev));
      exp.ch = 4'(acc);
      exp.ret = e_to[acc] ? 32'd0 : c_ret[acc];
      exp.cycles = 32'(e_cyc[acc]);
      exp.timeout = e_to[acc];
      chk("drain_rec", 128'(act), 128'(exp));
      if (res_valid && res_ready) acc++;
      stalled = res_valid && !res_ready;
      prev = act;
      n++;
    end
    chk("drain_accepts", 128'(acc), 128'(N));
    step();
    go = 1'b0;
    res_ready = 1'b0;
    drive_ch(t + 1);
    chk("end_busy", 128'(busy), 128'(0));
    chk("end_valid", 128'(res_valid), 128'(0));
  endtask

  task automatic abort_run();
    for (int i = 0; i < N; i++) begin
      c_pre[i] = 0;
      c_fall[i] = -1;
      c_rise[i] = -1;
      det[i] = -1;
      c_ret[i] = 32'(i);
    end
    step();
    go = 1'b1;
    drive_ch(-1);
    for (int k = 0; k < SD; k++) begin
      step();
      go = 1'b0;
      drive_ch(-1);
    end
    for (int t = 0; t < 10; t++) begin
      step();
      drive_ch(t);
    end
    chk("abort_pre", 128'(dut_start), 128'(4'hF));
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort_start", 128'(dut_start), 128'(0));
    chk("abort_valid", 128'(res_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("abort_idle", 128'(res_valid | busy), 128'(0));
    end
  endtask

  initial begin
    // Directed rows; per-channel fields list ch0 first.
    tbl[0].pre = 4'b0000;  tbl[0].fall = {4{8'hFF}};
    tbl[0].rise = {8'd57, 8'd20, 8'd3, 8'd44};
    tbl[0].ret = {32'h1F4, 32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003};
    tbl[0].mode = 2'd0;    tbl[0].noise = 1'b0;
    tbl[0].ecyc = {8'd57, 8'd20, 8'd3, 8'd44};  tbl[0].eto = 4'b0000;

    tbl[1].pre = 4'b0000;  tbl[1].fall = {4{8'hFF}};
    tbl[1].rise = {8'd30, 8'd10, 8'd30, 8'd5};
    tbl[1].ret = {32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
    tbl[1].mode = 2'd0;    tbl[1].noise = 1'b0;
    tbl[1].ecyc = {8'd30, 8'd10, 8'd30, 8'd5};  tbl[1].eto = 4'b0000;

    tbl[2].pre = 4'b0000;  tbl[2].fall = {4{8'hFF}};
    tbl[2].rise = {8'd12, 8'd40, 8'hFF, 8'd77};
    tbl[2].ret = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    tbl[2].mode = 2'd0;    tbl[2].noise = 1'b0;
    tbl[2].ecyc = {8'd12, 8'd40, 8'd100, 8'd77};  tbl[2].eto = 4'b0010;

    tbl[3].pre = 4'b0000;  tbl[3].fall = {4{8'hFF}};
    tbl[3].rise = {8'd8, 8'd0, 8'd15, 8'd2};
    tbl[3].ret = {32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003};
    tbl[3].mode = 2'd1;    tbl[3].noise = 1'b0;
    tbl[3].ecyc = {8'd8, 8'd0, 8'd15, 8'd2};  tbl[3].eto = 4'b0000;

    tbl[4].pre = 4'b1100;  tbl[4].fall = {8'hFF, 8'd3, 8'hFF, 8'hFF};
    tbl[4].rise = {8'hFF, 8'd9, 8'd9, 8'd25};
    tbl[4].ret = {32'h0F0F0F0F, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h01234567};
    tbl[4].mode = 2'd2;    tbl[4].noise = 1'b1;
    tbl[4].ecyc = {8'd100, 8'd9, 8'd9, 8'd25};  tbl[4].eto = 4'b1000;

    reset = 1'b0;
    step();
    step();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_start", 128'(dut_start), 128'(0));
    chk("rst_valid", 128'(res_valid), 128'(0));
    chk("rst_rec", 128'({res_ch, res_ret, res_cycles, res_timeout}), 128'(0));
    reset = 1'b1;

    for (int r = 0; r < NV; r++) begin
      load_row(tbl[r]);
      run_batch(int'(tbl[r].mode), tbl[r].noise);
    end

    abort_run();
    load_row(tbl[1]);
    run_batch(0, 1'b0);

    for (int r = 0; r < 15; r++) begin
      rand_row();
      run_batch(int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
